ts4231_configurator: RTL and testbench

TS4231_CONFIGURATOR -- requirements
Module: ts4231_configurator

---
 rtl/ts4231_configurator.sv | 227 ++++++++++++++++++++++
 tb/tb_ts4231_configurator.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ts4231_configurator.sv
// TS4231 light-sensor configurator: writes CONFIG_WORD over the D/E bus,
// reads it back, retries up to MAX_TRIES times, then reports done or error.
// Ports:
//   clk_96MHz, rst_n   : clock, async active-low reset
//   start              : one-cycle request (accepted in IDLE/DONE/ERR)
//   d_in               : sampled D line from the IO manager
//   d_oe/d_out         : D drive enable and value
//   e_oe/e_out         : E drive enable and value
//   busy/done/error    : status; readback = last word read
//   tries              : attempts used by current/last sequence
module ts4231_configurator #(
    parameter int          HALF_PERIOD = 48,
    parameter logic [14:0] CONFIG_WORD = 15'h392B,
    parameter int          MAX_TRIES   = 3
) (
    input  logic        clk_96MHz,
    input  logic        rst_n,
    input  logic        start,
    input  logic        d_in,
    output logic        d_oe,
    output logic        d_out,
    output logic        e_oe,
    output logic        e_out,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [14:0] readback,
    output logic [3:0]  tries
);

    typedef enum logic [3:0] {
        IDLE, WR_START, WR_BIT, WR_STOP,
        RD_START, RD_BIT, RD_STOP, CHECK,
        DONE, ERR
    } state_t;

    localparam logic [9:0] HP_M1 = 10'(HALF_PERIOD - 1);
    localparam logic [3:0] MAX_T = 4'(MAX_TRIES);

    state_t      state_q, state_d;
    logic [1:0]  phase_q, phase_d;
    logic [3:0]  bit_q, bit_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [14:0] shift_q, shift_d;
    logic [14:0] rdbk_q, rdbk_d;
    logic [3:0]  tries_q, tries_d;

    logic d_oe_q, d_oe_d, d_out_q, d_out_d;
    logic e_oe_q, e_oe_d, e_out_q, e_out_d;
    logic busy_q, busy_d, done_q, done_d;
    logic error_q, error_d;

    logic last;
    assign last = (cnt_q == 10'd0);

    // Next-state logic; each phase lasts HALF_PERIOD clocks.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        rdbk_d  = rdbk_q;
        tries_d = tries_q;
        unique case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = WR_START;
                    phase_d = 2'd0;
                    bit_d   = 4'd0;
                    cnt_d   = HP_M1;
                    tries_d = 4'd0;
                end
            end
            WR_START, RD_START: begin
                if (!last) begin
                    cnt_d = cnt_q - 10'd1;
                end else begin
                    cnt_d = HP_M1;
                    if (phase_q == 2'd2) begin
                        phase_d = 2'd0;
                        bit_d   = 4'd0;
                        state_d = (state_q == WR_START) ? WR_BIT : RD_BIT;
                    end else begin
                        phase_d = phase_q + 2'd1;
                    end
                end
            end
            WR_BIT, RD_BIT: begin
                if (!last) begin
                    cnt_d = cnt_q - 10'd1;
                end else begin
                    cnt_d = HP_M1;
                    // Sample at the end of the E-high phase.
                    if (state_q == RD_BIT && phase_q == 2'd1) begin
                        shift_d = {shift_q[13:0], d_in};
                    end
                    if (phase_q == 2'd2) begin
                        phase_d = 2'd0;
                        if (bit_q == 4'd14) begin
                            bit_d   = 4'd0;
                            state_d = (state_q == WR_BIT) ? WR_STOP : RD_STOP;
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end else begin
                        phase_d = phase_q + 2'd1;
                    end
                end
            end
            WR_STOP, RD_STOP: begin
                // Phase 3 is the released-bus phase after STOP.
                if (!last) begin
                    cnt_d = cnt_q - 10'd1;
                end else begin
                    cnt_d = HP_M1;
                    if (phase_q == 2'd3) begin
                        phase_d = 2'd0;
                        state_d = (state_q == WR_STOP) ? RD_START : CHECK;
                    end else begin
                        phase_d = phase_q + 2'd1;
                    end
                end
            end
            CHECK: begin
                rdbk_d  = shift_q;
                tries_d = tries_q + 4'd1;
                if (shift_q == CONFIG_WORD) begin
                    state_d = DONE;
                end else if (tries_d < MAX_T) begin
                    state_d = WR_START;
                    phase_d = 2'd0;
                    bit_d   = 4'd0;
                    cnt_d   = HP_M1;
                end else begin
                    state_d = ERR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the next state so the registers
    // line up with the state they describe.
    always_comb begin
        d_oe_d  = 1'b0;
        d_out_d = 1'b0;
        e_oe_d  = 1'b0;
        e_out_d = 1'b0;
        busy_d  = 1'b1;
        done_d  = (state_d == DONE);
        error_d = (state_d == ERR);
        unique case (state_d)
            IDLE, DONE, ERR: busy_d = 1'b0;
            WR_START, RD_START: begin
                d_oe_d  = 1'b1;
                e_oe_d  = 1'b1;
                d_out_d = (phase_d == 2'd0);
                e_out_d = (phase_d != 2'd2);
            end
            WR_BIT: begin
                d_oe_d  = 1'b1;
                e_oe_d  = 1'b1;
                d_out_d = CONFIG_WORD[4'd14 - bit_d];
                e_out_d = (phase_d == 2'd1);
            end
            RD_BIT: begin
                e_oe_d  = 1'b1;
                e_out_d = (phase_d == 2'd1);
            end
            WR_STOP, RD_STOP: begin
                if (phase_d != 2'd3) begin
                    d_oe_d  = 1'b1;
                    e_oe_d  = 1'b1;
                    d_out_d = (phase_d == 2'd2);
                    e_out_d = (phase_d != 2'd0);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_96MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            phase_q <= 2'd0;
            bit_q   <= 4'd0;
            cnt_q   <= 10'd0;
            shift_q <= 15'd0;
            rdbk_q  <= 15'd0;
            tries_q <= 4'd0;
            d_oe_q  <= 1'b0;
            d_out_q <= 1'b0;
            e_oe_q  <= 1'b0;
            e_out_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            rdbk_q  <= rdbk_d;
            tries_q <= tries_d;
            d_oe_q  <= d_oe_d;
            d_out_q <= d_out_d;
            e_oe_q  <= e_oe_d;
            e_out_q <= e_out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign d_oe     = d_oe_q;
    assign d_out    = d_out_q;
    assign e_oe     = e_oe_q;
    assign e_out    = e_out_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign readback = rdbk_q;
    assign tries    = tries_q;

endmodule

// File: tb/tb_ts4231_configurator.sv
// Directed bench for ts4231_configurator with a behavioural sensor
// model on a pulled-up D/E bus and a bus-rule monitor.
module tb_ts4231_configurator;

    localparam int HP = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        d_in;
    logic        d_oe, d_out, e_oe, e_out;
    logic        busy, done, error;
    logic [14:0] readback;
    logic [3:0]  tries;

    always #5 clk = ~clk;

    ts4231_configurator #(
        .HALF_PERIOD(HP),
        .CONFIG_WORD(15'h392B),
        .MAX_TRIES(3)
    ) dut (
        .clk_96MHz(clk),
        .rst_n(rst_n),
        .start(start),
        .d_in(d_in),
        .d_oe(d_oe),
        .d_out(d_out),
        .e_oe(e_oe),
        .e_out(e_out),
        .busy(busy),
        .done(done),
        .error(error),
        .readback(readback),
        .tries(tries)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sensor model and bus monitor (lines pulled up when released).
    logic        dl, el;
    logic        dl_p = 1'b1, el_p = 1'b1;
    int          start_cnt = 0, stop_cnt = 0, rdclk = 0;
    int          xbits = 15, rd_idx = 15, reads_done = 0;
    int          mode = 0, rd_base = 0;
    logic [14:0] wsh = 15'd0, wr_word = 15'd0, rword;

    assign dl = d_oe ? d_out : 1'b1;
    assign el = e_oe ? e_out : 1'b1;

    always @(negedge clk) begin
        // D edges while E high: fall = START, rise = STOP.
        if (el_p && el && dl_p && !dl) begin
            start_cnt++;
            xbits  = 0;
            rd_idx = 0;
        end else if (el_p && el && !dl_p && dl) begin
            stop_cnt++;
        end
        if (!el_p && el && xbits < 15) begin
            if (d_oe) begin
                wsh = {wsh[13:0], d_out};
                if (xbits == 14) wr_word = wsh;
            end
            xbits++;
        end
        if (el_p && !el && !d_oe && rd_idx < 15) begin
            rd_idx++;
            if (rd_idx == 15) reads_done++;
        end
        if (e_oe && !d_oe) rdclk++;
        dl_p = dl;
        el_p = el;
    end

    always_comb begin
        case (mode)
            1: rword = (reads_done == rd_base) ? 15'h0000 : wr_word;
            2: rword = 15'h7FFF;
            default: rword = wr_word;
        endcase
        d_in = 1'b0;
        if (!d_oe && rd_idx < 15) d_in = rword[14 - rd_idx];
    end

    int sb, pb, rb;

    task automatic snap();
        sb = start_cnt;
        pb = stop_cnt;
        rb = rdclk;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle(input bit spam, output int n);
        n = 0;
        for (int i = 1; i <= 3000; i++) begin
            @(posedge clk);
            #1;
            if (!busy) begin
                n = i;
                break;
            end
            start = spam && (i % 10 == 9);
        end
        start = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    int n;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs", {d_oe, d_out, e_oe, e_out, busy, done, error},
            7'd0);
        chk("rst_rdbk", readback, 15'd0);
        chk("rst_tries", tries, 4'd0);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("idle_hold", {busy, d_oe, e_oe, done}, 4'd0);

        // Echo sensor: one attempt
        mode = 0;
        snap();
        pulse_start();
        chk("busy_next", busy, 1'b1);
        wait_idle(1'b0, n);
        chk("run1_cycles", n, 417);
        chk("run1_done_err", {done, error}, 2'b10);
        chk("run1_rdbk", readback, 15'h392B);
        chk("run1_tries", tries, 4'd1);
        chk("run1_written", wr_word, 15'h392B);
        chk("run1_lines", {d_oe, e_oe, d_out, e_out}, 4'd0);
        chk("run1_starts", start_cnt - sb, 2);
        chk("run1_stops", stop_cnt - pb, 2);
        chk("run1_rdclk", rdclk - rb, 45 * HP);

        // First read returns zeros, second read correct
        mode = 1;
        rd_base = reads_done;
        snap();
        pulse_start();
        chk("run2_clear", {done, error, tries}, 6'd0);
        wait_idle(1'b0, n);
        chk("run2_cycles", n, 834);
        chk("run2_done_err", {done, error}, 2'b10);
        chk("run2_rdbk", readback, 15'h392B);
        chk("run2_tries", tries, 4'd2);
        chk("run2_starts", start_cnt - sb, 4);
        chk("run2_stops", stop_cnt - pb, 4);
        chk("run2_rdclk", rdclk - rb, 90 * HP);

        // Stuck-high sensor: retries exhausted
        mode = 2;
        snap();
        pulse_start();
        wait_idle(1'b0, n);
        chk("run3_cycles", n, 1251);
        chk("run3_done_err", {done, error}, 2'b01);
        chk("run3_tries", tries, 4'd3);
        chk("run3_rdbk", readback, 15'h7FFF);
        chk("run3_lines", {d_oe, e_oe, d_out, e_out}, 4'd0);
        chk("run3_rdclk", rdclk - rb, 135 * HP);
        repeat (5) @(posedge clk);
        #1;
        chk("run3_hold", {busy, done, error}, 3'b001);

        // Reset during the 7th read bit
        mode = 0;
        pulse_start();
        repeat (293) @(posedge clk);
        #1;
        chk("mid_rdbit", {e_oe, d_oe}, 2'b10);
        chk("mid_rdidx", rd_idx, 6);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {d_oe, e_oe, busy, d_out, e_out}, 5'd0);
        chk("mid_rst_stat", {done, error, tries}, 6'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_idle", busy, 1'b0);
        snap();
        pulse_start();
        wait_idle(1'b0, n);
        chk("run4_cycles", n, 417);
        chk("run4_done", {done, error, tries}, 6'b10_0001);
        chk("run4_rdbk", readback, 15'h392B);
        chk("run4_starts", start_cnt - sb, 2);

        // Start spammed while busy
        snap();
        pulse_start();
        wait_idle(1'b1, n);
        chk("run5_cycles", n, 417);
        chk("run5_tries", tries, 4'd1);
        chk("run5_done", {done, error}, 2'b10);
        chk("run5_starts", start_cnt - sb, 2);
        repeat (10) @(posedge clk);
        #1;
        chk("run5_quiet", {busy, done}, 2'b01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
